// File: rtl/kamus_wb_arbiter.sv
// Round-robin write-back arbiter with a registered register-file write port
// and a pending-write scoreboard that stalls decode on RAW/WAW hazards.
module kamus_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*5-1:0]    req_rd_addr_i,
  input  logic [NUM_REQ*XLEN-1:0] req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rf_we_o,
  output logic [4:0]              rf_rd_addr_o,
  output logic [XLEN-1:0]         rf_wr_data_o,
  input  logic                    issue_valid_i,
  input  logic [4:0]              issue_rd_addr_i,
  input  logic                    issue_writes_rd_i,
  input  logic [4:0]              rs1_addr_i,
  input  logic [4:0]              rs2_addr_i,
  output logic                    stall_o,
  output logic [31:0]             pending_o
);

  localparam int unsigned PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int unsigned AW    = 5;

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] cand;
  logic             found;
  logic [AW-1:0]    rd_arr   [NUM_REQ];
  logic [XLEN-1:0]  data_arr [NUM_REQ];
  logic [31:0]      pending_q;
  logic [31:0]      pending_d;
  logic [31:0]      set_vec;
  logic [31:0]      clr_vec;
  logic             issue_accept;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign rd_arr[g]   = req_rd_addr_i[g*AW +: AW];
    assign data_arr[g] = req_data_i[g*XLEN +: XLEN];
  end

  // First valid requester at or after rr_ptr, wrapping; nothing granted in reset.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        found   = 1'b1;
        gnt_idx = cand;
      end
    end
    if (rst_i) found = 1'b0;
  end

  assign req_ready_o = NUM_REQ'(found) << gnt_idx;

  // Hazard check against outstanding writes; no bypass from the write port.
  always_comb begin
    stall_o = 1'b0;
    if (!rst_i) begin
      stall_o = pending_q[rs1_addr_i] | pending_q[rs2_addr_i] |
                (issue_writes_rd_i & pending_q[issue_rd_addr_i]);
    end
  end

  assign issue_accept = issue_valid_i & ~stall_o & issue_writes_rd_i &
                        (issue_rd_addr_i != '0);

  // Clear from the write port, then set from issue so a same-register collision keeps the bit.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (rf_we_o)      clr_vec[rf_rd_addr_o]    = 1'b1;
    if (issue_accept) set_vec[issue_rd_addr_i] = 1'b1;
    pending_d = ((pending_q & ~clr_vec) | set_vec) & ~32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr       <= '0;
      rf_we_o      <= 1'b0;
      rf_rd_addr_o <= '0;
      rf_wr_data_o <= '0;
      pending_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (found) begin
        rr_ptr       <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
        rf_we_o      <= (rd_arr[gnt_idx] != '0);
        rf_rd_addr_o <= rd_arr[gnt_idx];
        rf_wr_data_o <= data_arr[gnt_idx];
      end else begin
        rf_we_o <= 1'b0;
      end
    end
  end

  assign pending_o = pending_q;

endmodule

// File: tb/tb_kamus_wb_arbiter.sv
// Directed bench for kamus_wb_arbiter: arbitration order, write-port latency,
// scoreboard set/clear and stall behaviour, and mid-operation reset.
module tb_kamus_wb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  req_valid_i;
  logic [14:0] req_rd_addr_i;
  logic [95:0] req_data_i;
  logic [2:0]  req_ready_o;
  logic        rf_we_o;
  logic [4:0]  rf_rd_addr_o;
  logic [31:0] rf_wr_data_o;
  logic        issue_valid_i;
  logic [4:0]  issue_rd_addr_i;
  logic        issue_writes_rd_i;
  logic [4:0]  rs1_addr_i;
  logic [4:0]  rs2_addr_i;
  logic        stall_o;
  logic [31:0] pending_o;

  int passed = 0;
  int total  = 0;

  kamus_wb_arbiter #(.NUM_REQ(3), .XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_rd_addr_i(req_rd_addr_i), .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .rf_we_o(rf_we_o), .rf_rd_addr_o(rf_rd_addr_o), .rf_wr_data_o(rf_wr_data_o),
    .issue_valid_i(issue_valid_i), .issue_rd_addr_i(issue_rd_addr_i),
    .issue_writes_rd_i(issue_writes_rd_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
    .stall_o(stall_o), .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_req(input int k, input logic [4:0] rd, input logic [31:0] d);
    req_rd_addr_i[k*5 +: 5] = rd;
    req_data_i[k*32 +: 32]  = d;
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic w);
    issue_valid_i     = v;
    issue_rd_addr_i   = rd;
    issue_writes_rd_i = w;
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = '0; req_rd_addr_i = '0; req_data_i = '0;
    issue(1'b0, 5'd0, 1'b0);
    rs1_addr_i = '0; rs2_addr_i = '0;
    tick(); tick();
    chk("rst_we", 32'(rf_we_o), 32'd0);
    chk("rst_addr", 32'(rf_rd_addr_o), 32'd0);
    chk("rst_data", rf_wr_data_o, 32'd0);
    chk("rst_pending", pending_o, 32'd0);

    // All three requesters valid; no grant while in reset
    set_req(0, 5'd1, 32'h100); set_req(1, 5'd2, 32'h101); set_req(2, 5'd3, 32'h102);
    req_valid_i = 3'b111;
    #1;
    chk("rst_ready", 32'(req_ready_o), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    tick();
    rst_i = 1'b0;
    #1;
    chk("rr_c0_ready", 32'(req_ready_o), 32'b001);
    chk("rr_c0_we", 32'(rf_we_o), 32'd0);
    tick();
    chk("rr_c1_ready", 32'(req_ready_o), 32'b010);
    chk("rr_c1_we", 32'(rf_we_o), 32'd1);
    chk("rr_c1_addr", 32'(rf_rd_addr_o), 32'd1);
    chk("rr_c1_data", rf_wr_data_o, 32'h100);
    tick();
    chk("rr_c2_ready", 32'(req_ready_o), 32'b100);
    chk("rr_c2_addr", 32'(rf_rd_addr_o), 32'd2);
    chk("rr_c2_data", rf_wr_data_o, 32'h101);
    tick();
    chk("rr_c3_ready", 32'(req_ready_o), 32'b001);
    chk("rr_c3_addr", 32'(rf_rd_addr_o), 32'd3);
    tick();
    chk("rr_c4_ready", 32'(req_ready_o), 32'b010);
    chk("rr_c4_addr", 32'(rf_rd_addr_o), 32'd1);
    req_valid_i = 3'b000;
    #1;
    chk("idle_ready", 32'(req_ready_o), 32'd0);
    tick();
    chk("idle_we", 32'(rf_we_o), 32'd0);

    // Pointer at 1, requesters 0 and 2 valid: 2 wins, then pointer wraps to 0
    req_valid_i = 3'b101;
    #1;
    chk("skip_ready", 32'(req_ready_o), 32'b100);
    tick();
    req_valid_i = 3'b000;
    chk("skip_addr", 32'(rf_rd_addr_o), 32'd3);
    req_valid_i = 3'b101;
    #1;
    chk("wrap_ready", 32'(req_ready_o), 32'b001);
    req_valid_i = 3'b000;
    tick();
    chk("nowrap_we", 32'(rf_we_o), 32'd0);

    // Issue rd=5, RAW stall on rs1=5 until write-back retires
    issue(1'b1, 5'd5, 1'b1);
    #1;
    chk("iss5_stall", 32'(stall_o), 32'd0);
    tick();
    issue(1'b0, 5'd0, 1'b0);
    rs1_addr_i = 5'd5;
    #1;
    chk("iss5_pending", pending_o, 32'h20);
    chk("raw5_stall", 32'(stall_o), 32'd1);
    set_req(0, 5'd5, 32'hDEADBEEF);
    req_valid_i = 3'b001;
    #1;
    chk("wb5_ready", 32'(req_ready_o), 32'b001);
    tick();
    req_valid_i = 3'b000;
    #1;
    chk("wb5_we", 32'(rf_we_o), 32'd1);
    chk("wb5_addr", 32'(rf_rd_addr_o), 32'd5);
    chk("wb5_data", rf_wr_data_o, 32'hDEADBEEF);
    chk("wb5_still_pending", pending_o, 32'h20);
    chk("wb5_still_stall", 32'(stall_o), 32'd1);
    tick();
    chk("wb5_cleared", pending_o, 32'd0);
    chk("wb5_unstall", 32'(stall_o), 32'd0);
    rs1_addr_i = 5'd0;

    // rd=0: no scoreboard entry, transfer accepted but no write
    issue(1'b1, 5'd0, 1'b1);
    tick();
    issue(1'b0, 5'd0, 1'b0);
    chk("x0_pending", pending_o, 32'd0);
    set_req(1, 5'd0, 32'h55);
    req_valid_i = 3'b010;
    #1;
    chk("x0_ready", 32'(req_ready_o), 32'b010);
    tick();
    req_valid_i = 3'b000;
    chk("x0_we", 32'(rf_we_o), 32'd0);

    // Write-back to a non-pending register still writes (pointer now 2, LSU wins)
    set_req(1, 5'd4, 32'h44);
    req_valid_i = 3'b010;
    #1;
    chk("np_ready", 32'(req_ready_o), 32'b010);
    tick();
    req_valid_i = 3'b000;
    chk("np_we", 32'(rf_we_o), 32'd1);
    chk("np_addr", 32'(rf_rd_addr_o), 32'd4);
    tick();
    chk("np_pending", pending_o, 32'd0);

    // rd=7 pending, retiring while a second rd=7 issue waits on WAW
    issue(1'b1, 5'd7, 1'b1);
    tick();
    issue(1'b0, 5'd0, 1'b0);
    chk("p7_set", pending_o, 32'h80);
    set_req(0, 5'd7, 32'h77);
    req_valid_i = 3'b001;
    #1;
    chk("p7_ready", 32'(req_ready_o), 32'b001);
    tick();
    req_valid_i = 3'b000;
    issue(1'b1, 5'd7, 1'b1);
    #1;
    chk("p7_we", 32'(rf_we_o), 32'd1);
    chk("p7_waw_stall", 32'(stall_o), 32'd1);
    tick();
    issue(1'b0, 5'd0, 1'b0);
    chk("p7_cleared", pending_o, 32'd0);

    // WAW on rd=9 holds decode and leaves the scoreboard unchanged
    issue(1'b1, 5'd9, 1'b1);
    tick();
    chk("p9_set", pending_o, 32'h200);
    #1;
    chk("p9_waw_stall", 32'(stall_o), 32'd1);
    tick();
    chk("p9_unchanged", pending_o, 32'h200);
    issue(1'b0, 5'd0, 1'b0);
    rs2_addr_i = 5'd9;
    #1;
    chk("p9_raw_rs2", 32'(stall_o), 32'd1);
    rs2_addr_i = 5'd0;
    set_req(2, 5'd9, 32'h99);
    req_valid_i = 3'b100;
    #1;
    chk("p9_ready", 32'(req_ready_o), 32'b100);
    tick();
    req_valid_i = 3'b000;
    tick();
    chk("p9_cleared", pending_o, 32'd0);

    // Build pending 0x410, put a transfer in flight, then pulse reset
    issue(1'b1, 5'd4, 1'b1);
    tick();
    issue(1'b1, 5'd10, 1'b1);
    tick();
    issue(1'b0, 5'd0, 1'b0);
    chk("pre_rst_pending", pending_o, 32'h410);
    set_req(0, 5'd1, 32'h100); set_req(1, 5'd2, 32'h101); set_req(2, 5'd3, 32'h102);
    req_valid_i = 3'b111;
    #1;
    chk("pre_rst_ready", 32'(req_ready_o), 32'b001);
    tick();
    rst_i = 1'b1;
    rs1_addr_i = 5'd4;
    #1;
    chk("mid_rst_ready", 32'(req_ready_o), 32'd0);
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    tick();
    rst_i = 1'b0;
    rs1_addr_i = 5'd0;
    #1;
    chk("post_rst_pending", pending_o, 32'd0);
    chk("post_rst_we", 32'(rf_we_o), 32'd0);
    chk("post_rst_ready", 32'(req_ready_o), 32'b001);
    tick();
    chk("post_rst_wb_we", 32'(rf_we_o), 32'd1);
    chk("post_rst_wb_addr", 32'(rf_rd_addr_o), 32'd1);
    req_valid_i = 3'b000;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
